// File: rtl/usb_fs_pkg.sv
// Shared types and constants for the full-speed USB receive front-end.
//   line_state_t : decoded {D+, D-} pair (J, K, SE0, SE1)
//   rx_state_t   : framing FSM states
//   decode_line  : maps the synchronised {D+, D-} pair onto line_state_t
package usb_fs_pkg;

   typedef enum logic [1:0] {
      LS_SE0 = 2'b00,
      LS_K   = 2'b01,
      LS_J   = 2'b10,
      LS_SE1 = 2'b11
   } line_state_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SYNC,
      ST_DATA,
      ST_EOP
   } rx_state_t;

   localparam int unsigned SYNC_PID_BITS = 8;
   localparam int unsigned STUFF_LIMIT   = 6;

   // {D+, D-} maps one-to-one onto the enum encoding.
   function automatic line_state_t decode_line(input logic dp, input logic dn);
      return line_state_t'({dp, dn});
   endfunction

endpackage

// File: rtl/usb_fs_bit_recovery.sv
// Line synchroniser, line-state decode and 4x-oversampling bit timing.
//   i_clk / i_rst_n : 48 MHz clock, async active-low reset
//   i_dp / i_dn     : raw asynchronous D+ / D-
//   o_line_state    : synchronised, decoded line state (registered)
//   o_bit_strobe    : high in the cycle o_line_state should be sampled (registered)
module usb_fs_bit_recovery
   import usb_fs_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_dp,
   input  logic        i_dn,
   output line_state_t o_line_state,
   output logic        o_bit_strobe
);

   logic [1:0]  r_dp_sync;
   logic [1:0]  r_dn_sync;
   line_state_t r_line_state;
   logic [1:0]  r_phase;
   logic        r_bit_strobe;
   line_state_t w_line_now;
   logic [1:0]  w_phase_nxt;

   assign w_line_now  = decode_line(r_dp_sync[1], r_dn_sync[1]);
   // Any line transition re-centres the sampling point; otherwise free-run mod 4.
   assign w_phase_nxt = (w_line_now != r_line_state) ? 2'd0 : r_phase + 2'd1;

   // Synchronisers come out of reset at idle J so no spurious SE0 is seen.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dp_sync    <= 2'b11;
         r_dn_sync    <= 2'b00;
         r_line_state <= LS_J;
         r_phase      <= 2'd0;
         r_bit_strobe <= 1'b0;
      end else begin
         r_dp_sync    <= {r_dp_sync[0], i_dp};
         r_dn_sync    <= {r_dn_sync[0], i_dn};
         r_line_state <= w_line_now;
         r_phase      <= w_phase_nxt;
         r_bit_strobe <= (w_phase_nxt == 2'd2);
      end
   end

   assign o_line_state = r_line_state;
   assign o_bit_strobe = r_bit_strobe;

endmodule

// File: rtl/usb_fs_rx_phy.sv
// Full-speed USB receive front-end: SYNC detect, NRZI decode, bit unstuffing,
// byte framing, EOP / error flagging and bus-reset detection.
//   clk_48mhz, reset_n   : clock, async active-low reset
//   usb_p_rx, usb_n_rx   : raw D+ / D-
//   rx_en                : low while the device transmits (echo suppression)
//   pkt_start            : pulse after SYNC
//   rx_data / rx_valid   : received byte (LSB first on wire) and its pulse
//   pkt_end              : pulse on a byte-aligned EOP
//   rx_err               : pulse on stuff error, SE1 or misaligned EOP
//   usb_reset            : level, SE0 held for RESET_CYCLES or more
module usb_fs_rx_phy
   import usb_fs_pkg::*;
#(
   parameter int unsigned RESET_CYCLES   = 120,
   parameter int unsigned SYNC_MIN_ZEROS = 3
) (
   input  logic       clk_48mhz,
   input  logic       reset_n,
   input  logic       usb_p_rx,
   input  logic       usb_n_rx,
   input  logic       rx_en,
   output logic       pkt_start,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       pkt_end,
   output logic       rx_err,
   output logic       usb_reset
);

   localparam int unsigned RST_CNT_W = $clog2(RESET_CYCLES + 1);
   localparam int unsigned ZERO_W    = $clog2(SYNC_MIN_ZEROS + 1);
   localparam int unsigned ONES_W    = $clog2(STUFF_LIMIT + 1);
   localparam int unsigned BIT_CNT_W = $clog2(SYNC_PID_BITS);

   line_state_t          w_line_state;
   logic                 w_bit_strobe;
   logic                 w_bit;
   logic                 w_is_jk;

   rx_state_t            r_state;
   line_state_t          r_prev_ls;
   logic [ZERO_W-1:0]    r_zero_cnt;
   logic [ONES_W-1:0]    r_ones_cnt;
   logic [BIT_CNT_W-1:0] r_bit_cnt;
   logic [6:0]           r_shift;
   logic                 r_eop_se0;
   logic                 r_aligned;
   logic [RST_CNT_W-1:0] r_rst_cnt;
   logic                 r_usb_reset;
   logic                 r_pkt_start;
   logic [7:0]           r_rx_data;
   logic                 r_rx_valid;
   logic                 r_pkt_end;
   logic                 r_rx_err;

   usb_fs_bit_recovery u_bit_rec (
      .i_clk        (clk_48mhz),
      .i_rst_n      (reset_n),
      .i_dp         (usb_p_rx),
      .i_dn         (usb_n_rx),
      .o_line_state (w_line_state),
      .o_bit_strobe (w_bit_strobe)
   );

   // NRZI: no transition decodes as 1.
   assign w_bit   = (w_line_state == r_prev_ls);
   assign w_is_jk = (w_line_state == LS_J) || (w_line_state == LS_K);

   // Bus reset: consecutive SE0 cycles, independent of rx_en.
   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) begin
         r_rst_cnt   <= '0;
         r_usb_reset <= 1'b0;
      end else if (w_line_state == LS_SE0) begin
         if (r_rst_cnt != RST_CNT_W'(RESET_CYCLES)) r_rst_cnt <= r_rst_cnt + RST_CNT_W'(1);
         if (r_rst_cnt >= RST_CNT_W'(RESET_CYCLES - 1)) r_usb_reset <= 1'b1;
      end else begin
         r_rst_cnt   <= '0;
         r_usb_reset <= 1'b0;
      end
   end

   // Framing FSM; all pulses default low each cycle.
   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_prev_ls   <= LS_J;
         r_zero_cnt  <= '0;
         r_ones_cnt  <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_eop_se0   <= 1'b0;
         r_aligned   <= 1'b0;
         r_pkt_start <= 1'b0;
         r_rx_data   <= 8'h00;
         r_rx_valid  <= 1'b0;
         r_pkt_end   <= 1'b0;
         r_rx_err    <= 1'b0;
      end else begin
         r_pkt_start <= 1'b0;
         r_rx_valid  <= 1'b0;
         r_pkt_end   <= 1'b0;
         r_rx_err    <= 1'b0;
         if (!rx_en || r_usb_reset) begin
            r_state   <= ST_IDLE;
            r_prev_ls <= LS_J;
         end else if (w_bit_strobe) begin
            case (r_state)
               ST_IDLE: begin
                  r_prev_ls <= LS_J;
                  if (w_line_state == LS_K) begin
                     // First K after idle J is the first SYNC zero.
                     r_state    <= ST_SYNC;
                     r_prev_ls  <= LS_K;
                     r_zero_cnt <= ZERO_W'(1);
                  end
               end
               ST_SYNC: begin
                  if (!w_is_jk) begin
                     r_state   <= ST_IDLE;
                     r_prev_ls <= LS_J;
                  end else begin
                     r_prev_ls <= w_line_state;
                     if (!w_bit) begin
                        if (r_zero_cnt < ZERO_W'(SYNC_MIN_ZEROS)) r_zero_cnt <= r_zero_cnt + ZERO_W'(1);
                     end else if (r_zero_cnt >= ZERO_W'(SYNC_MIN_ZEROS)) begin
                        r_pkt_start <= 1'b1;
                        r_bit_cnt   <= '0;
                        r_ones_cnt  <= '0;
                        r_state     <= ST_DATA;
                     end else begin
                        r_state   <= ST_IDLE;
                        r_prev_ls <= LS_J;
                     end
                  end
               end
               ST_DATA: begin
                  if (w_line_state == LS_SE0) begin
                     r_state   <= ST_EOP;
                     r_eop_se0 <= 1'b1;
                     r_aligned <= (r_bit_cnt == '0);
                  end else if (w_line_state == LS_SE1) begin
                     r_rx_err  <= 1'b1;
                     r_state   <= ST_EOP;
                     r_eop_se0 <= 1'b0;
                  end else begin
                     r_prev_ls <= w_line_state;
                     if (r_ones_cnt == ONES_W'(STUFF_LIMIT)) begin
                        // Bit after six ones must be a stuffed zero.
                        if (w_bit) begin
                           r_rx_err  <= 1'b1;
                           r_state   <= ST_EOP;
                           r_eop_se0 <= 1'b0;
                        end else begin
                           r_ones_cnt <= '0;
                        end
                     end else begin
                        r_ones_cnt <= w_bit ? r_ones_cnt + ONES_W'(1) : '0;
                        r_shift    <= {w_bit, r_shift[6:1]};
                        r_bit_cnt  <= r_bit_cnt + BIT_CNT_W'(1);
                        if (r_bit_cnt == '1) begin
                           r_rx_data  <= {w_bit, r_shift};
                           r_rx_valid <= 1'b1;
                        end
                     end
                  end
               end
               ST_EOP: begin
                  if (w_line_state == LS_J) begin
                     r_state   <= ST_IDLE;
                     r_prev_ls <= LS_J;
                     if (r_eop_se0) begin
                        if (r_aligned) r_pkt_end <= 1'b1;
                        else           r_rx_err  <= 1'b1;
                     end
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign pkt_start = r_pkt_start;
   assign rx_data   = r_rx_data;
   assign rx_valid  = r_rx_valid;
   assign pkt_end   = r_pkt_end;
   assign rx_err    = r_rx_err;
   assign usb_reset = r_usb_reset;

endmodule

// File: tb/tb_usb_fs_rx_phy.sv
// Self-checking bench for usb_fs_rx_phy: directed vector table, hand-written
// bus-reset / reset_n sequences, and randomized packets with timing drift.
module tb_usb_fs_rx_phy;

   // Edges from a pad change until the decoded line state reflects it.
   localparam int SYNC_LAT = 3;
   localparam int RST_CYC  = 120;
   localparam logic [1:0] SJ = 2'b10, SK = 2'b01, S0 = 2'b00, S1 = 2'b11;

   logic       clk_48mhz = 1'b0;
   logic       reset_n   = 1'b0;
   logic       usb_p_rx  = 1'b1;
   logic       usb_n_rx  = 1'b0;
   logic       rx_en     = 1'b1;
   logic       pkt_start, rx_valid, pkt_end, rx_err, usb_reset;
   logic [7:0] rx_data;

   usb_fs_rx_phy #(.RESET_CYCLES(RST_CYC), .SYNC_MIN_ZEROS(3)) dut (
      .clk_48mhz (clk_48mhz),
      .reset_n   (reset_n),
      .usb_p_rx  (usb_p_rx),
      .usb_n_rx  (usb_n_rx),
      .rx_en     (rx_en),
      .pkt_start (pkt_start),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .pkt_end   (pkt_end),
      .rx_err    (rx_err),
      .usb_reset (usb_reset)
   );

   always #10 clk_48mhz = ~clk_48mhz;

   int checks = 0;
   int errors = 0;

   // Event monitor, sampled mid-cycle.
   int         mon_start, mon_end, mon_err;
   logic [7:0] mon_bytes[$];
   always @(negedge clk_48mhz) begin
      if (pkt_start) mon_start++;
      if (pkt_end)   mon_end++;
      if (rx_err)    mon_err++;
      if (rx_valid)  mon_bytes.push_back(rx_data);
   end

   task automatic mon_clear();
      mon_start = 0; mon_end = 0; mon_err = 0; mon_bytes.delete();
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   // ---------------- host-side encoder (reference model) ----------------
   logic [7:0] tx_bytes[$];
   logic [7:0] exp_bytes[$];
   logic [1:0] syms[$];
   logic [1:0] enc_lvl;
   int         enc_ones;

   task automatic put_bit(input bit b);
      if (!b) enc_lvl = (enc_lvl == SJ) ? SK : SJ;
      syms.push_back(enc_lvl);
   endtask

   task automatic put_data_bit(input bit b);
      put_bit(b);
      enc_ones = b ? enc_ones + 1 : 0;
      if (enc_ones == 6) begin
         put_bit(1'b0);
         enc_ones = 0;
      end
   endtask

   // SYNC, tx_bytes and n_extra partial bits (all stuffed), n_raw unstuffed
   // bits, then either SE0 SE0 J or SE1 J.
   task automatic build_pkt(input int n_extra, input logic [7:0] extra,
                            input int n_raw, input logic [7:0] raw, input bit se1_end);
      syms.delete();
      enc_lvl  = SJ;
      enc_ones = 0;
      for (int i = 0; i < 7; i++) put_bit(1'b0);
      put_bit(1'b1);
      foreach (tx_bytes[i])
         for (int k = 0; k < 8; k++) put_data_bit(tx_bytes[i][k]);
      for (int k = 0; k < n_extra; k++) put_data_bit(extra[k]);
      for (int k = 0; k < n_raw; k++) put_bit(raw[k]);
      if (se1_end) begin
         syms.push_back(S1); syms.push_back(SJ);
      end else begin
         syms.push_back(S0); syms.push_back(S0); syms.push_back(SJ);
      end
   endtask

   task automatic drive(input logic [1:0] s);
      {usb_p_rx, usb_n_rx} = s;
   endtask

   task automatic idle(input int n);
      drive(SJ);
      repeat (n) @(negedge clk_48mhz);
   endtask

   // 4 clocks per symbol; with drift, isolated J/K symbols last 3..5 clocks.
   task automatic send_syms(input int count, input bit drift);
      for (int i = 0; i < count; i++) begin
         int d;
         d = 4;
         if (drift && i > 0 && i < syms.size() - 1 && syms[i] != syms[i-1] &&
             syms[i] != syms[i+1] && (syms[i] == SJ || syms[i] == SK))
            d = $urandom_range(3, 5);
         drive(syms[i]);
         repeat (d) @(negedge clk_48mhz);
      end
   endtask

   task automatic run_and_check(input string tag, input int e_start, input int e_end,
                                input int e_err, input bit drift);
      int n;
      mon_clear();
      send_syms(syms.size(), drift);
      idle(24);
      chk({tag, " pkt_start"}, mon_start, e_start);
      chk({tag, " rx_valid count"}, mon_bytes.size(), exp_bytes.size());
      n = (mon_bytes.size() < exp_bytes.size()) ? mon_bytes.size() : exp_bytes.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s byte%0d", tag, i), int'(mon_bytes[i]), int'(exp_bytes[i]));
      chk({tag, " pkt_end"}, mon_end, e_end);
      chk({tag, " rx_err"}, mon_err, e_err);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      string      name;
      int         nb;
      logic [7:0] b0, b1, b2;
      int         n_extra;
      logic [7:0] extra;
      int         n_raw;
      logic [7:0] raw;
      bit         se1;
      bit         en;
      int         e_start, e_nvalid, e_end, e_err;
   } vec_t;

   vec_t tbl[7];

   task automatic bus_reset_run(input int n, output int rise_at, output int fall_at);
      rise_at = -1;
      fall_at = -1;
      drive(S0);
      for (int i = 1; i <= n + 20; i++) begin
         @(negedge clk_48mhz);
         if (usb_reset && rise_at < 0) rise_at = i;
         if (!usb_reset && rise_at >= 0 && fall_at < 0) fall_at = i;
         if (i == n) drive(SJ);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int rise, fall;
      tbl[0] = '{"setup",    3, 8'h2D, 8'h00, 8'h10, 0, 8'h00, 0, 8'h00, 1'b0, 1'b1, 1, 3, 1, 0};
      tbl[1] = '{"stuff",    2, 8'hFF, 8'hFF, 8'h00, 0, 8'h00, 0, 8'h00, 1'b0, 1'b1, 1, 2, 1, 0};
      tbl[2] = '{"stufferr", 1, 8'h69, 8'h00, 8'h00, 0, 8'h00, 7, 8'h7F, 1'b0, 1'b1, 1, 1, 0, 1};
      tbl[3] = '{"misalign", 1, 8'hA5, 8'h00, 8'h00, 4, 8'h05, 0, 8'h00, 1'b0, 1'b1, 1, 1, 0, 1};
      tbl[4] = '{"se1",      1, 8'hC3, 8'h00, 8'h00, 0, 8'h00, 0, 8'h00, 1'b1, 1'b1, 1, 1, 0, 1};
      tbl[5] = '{"echo",     3, 8'h2D, 8'h00, 8'h10, 0, 8'h00, 0, 8'h00, 1'b0, 1'b0, 0, 0, 0, 0};
      tbl[6] = '{"stuff3f",  2, 8'h3F, 8'hFC, 8'h00, 0, 8'h00, 0, 8'h00, 1'b0, 1'b1, 1, 2, 1, 0};

      // Reset state
      mon_clear();
      drive(SJ);
      repeat (5) @(negedge clk_48mhz);
      chk("reset pkt_start", int'(pkt_start), 0);
      chk("reset rx_data",   int'(rx_data),   0);
      chk("reset rx_valid",  int'(rx_valid),  0);
      chk("reset pkt_end",   int'(pkt_end),   0);
      chk("reset rx_err",    int'(rx_err),    0);
      chk("reset usb_reset", int'(usb_reset), 0);
      reset_n = 1'b1;
      idle(20);

      // Directed table
      for (int v = 0; v < 7; v++) begin
         tx_bytes.delete();
         tx_bytes.push_back(tbl[v].b0);
         if (tbl[v].nb > 1) tx_bytes.push_back(tbl[v].b1);
         if (tbl[v].nb > 2) tx_bytes.push_back(tbl[v].b2);
         build_pkt(tbl[v].n_extra, tbl[v].extra, tbl[v].n_raw, tbl[v].raw, tbl[v].se1);
         exp_bytes.delete();
         for (int k = 0; k < tbl[v].e_nvalid; k++) exp_bytes.push_back(tx_bytes[k]);
         rx_en = tbl[v].en;
         run_and_check(tbl[v].name, tbl[v].e_start, tbl[v].e_end, tbl[v].e_err, 1'b0);
         rx_en = 1'b1;
         idle(8);
      end

      // Bus reset: 200 clocks of SE0
      mon_clear();
      bus_reset_run(200, rise, fall);
      chk("busrst200 rise", rise, RST_CYC + SYNC_LAT);
      chk("busrst200 fall", fall, 200 + SYNC_LAT + 1);
      chk("busrst200 pkt_end", mon_end, 0);
      chk("busrst200 rx_err", mon_err, 0);
      idle(10);
      // 119 clocks of SE0 never reaches the threshold
      bus_reset_run(RST_CYC - 1, rise, fall);
      chk("busrst119 rise", rise, -1);
      idle(10);

      // reset_n mid-byte: first byte out, reset inside the second
      tx_bytes.delete();
      tx_bytes.push_back(8'h5A);
      tx_bytes.push_back(8'h33);
      build_pkt(0, 8'h00, 0, 8'h00, 1'b0);
      mon_clear();
      send_syms(20, 1'b0);
      chk("midrst pre pkt_start", mon_start, 1);
      chk("midrst pre byte", (mon_bytes.size() == 1) ? int'(mon_bytes[0]) : -1, 8'h5A);
      reset_n = 1'b0;
      drive(SJ);
      #1;
      chk("midrst rx_data",   int'(rx_data),   0);
      chk("midrst pkt_start", int'(pkt_start), 0);
      chk("midrst rx_valid",  int'(rx_valid),  0);
      chk("midrst pkt_end",   int'(pkt_end),   0);
      chk("midrst rx_err",    int'(rx_err),    0);
      chk("midrst usb_reset", int'(usb_reset), 0);
      repeat (3) @(negedge clk_48mhz);
      reset_n = 1'b1;
      idle(20);
      tx_bytes.delete();
      tx_bytes.push_back(8'h2D);
      tx_bytes.push_back(8'h00);
      tx_bytes.push_back(8'h10);
      build_pkt(0, 8'h00, 0, 8'h00, 1'b0);
      exp_bytes = tx_bytes;
      run_and_check("after_rst", 1, 1, 0, 1'b0);

      // Randomized packets with drift: every complete byte comes back in order;
      // a trailing partial byte turns the EOP into an error.
      for (int r = 0; r < 40; r++) begin
         int nb, nx;
         nb = $urandom_range(1, 5);
         tx_bytes.delete();
         for (int k = 0; k < nb; k++)
            tx_bytes.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
         nx = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 7);
         build_pkt(nx, 8'($urandom), 0, 8'h00, 1'b0);
         exp_bytes = tx_bytes;
         run_and_check($sformatf("rand%0d", r), 1, (nx == 0) ? 1 : 0, (nx != 0) ? 1 : 0, 1'b1);
         idle(4);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/usb_fs_rx_phy.md
Name: usb_fs_rx_phy

Overview:
Full-speed USB receive front-end. It consumes the raw usb_p_rx/usb_n_rx pair as driven by the host model and delivers decoded packet bytes to the bootloader's protocol engine.
Internally it synchronises the line, recovers bit timing by 4x oversampling at 48 MHz, and detects SYNC. It then NRZI-decodes, removes stuffed bits and frames bytes, and flags EOP, errors and bus reset.
It sits between the USB pads and the packet/PID decoder.

Parameters:
RESET_CYCLES, 120, consecutive SE0 clocks that declare bus reset (2.5 us at 48 MHz)
SYNC_MIN_ZEROS, 3, minimum decoded SYNC zeros before the terminating one (tolerates hub-truncated SYNC)

Ports:
clk_48mhz  in  1  system clock, 48 MHz
reset_n  in  1  asynchronous active-low reset
usb_p_rx  in  1  raw D+ (asynchronous)
usb_n_rx  in  1  raw D- (asynchronous)
rx_en  in  1  low while the device transmits (usb_tx_en high); suppresses echo
pkt_start  out  1  one-cycle pulse when SYNC completes
rx_data  out  8  received byte, LSB = first bit on the wire
rx_valid  out  1  one-cycle pulse; rx_data valid
pkt_end  out  1  one-cycle pulse on a valid EOP (SE0 then J)
rx_err  out  1  one-cycle pulse on stuff error, misaligned EOP or SE1
usb_reset  out  1  level; high while SE0 has persisted for RESET_CYCLES or more

Behaviour:
- Reset values: all outputs 0, rx_data 8'h00, FSM IDLE, phase counter 0.
- Input path: two-FF synchroniser per line.
- Line-state decode: J = (1,0), K = (0,1), SE0 = (0,0), SE1 = (1,1).
- Bit recovery:
  - 2-bit phase counter; reset to 0 on any synchronised line-state change, otherwise increments and wraps 3->0.
  - A bit is sampled when phase == 2.
  - NRZI decode: bit = 1 if the sampled state equals the previous sampled state, else 0. The previous state is J at IDLE entry.
- FSM states: IDLE, SYNC, DATA, EOP.
  - IDLE: on sampled K, go to SYNC with zero count = 1.
  - SYNC:
    - Each decoded 0 increments the zero count (saturating).
    - A decoded 1 with zero count >= SYNC_MIN_ZEROS pulses pkt_start in the next cycle, clears the bit and ones counters, and goes to DATA.
    - A decoded 1 with zero count below the minimum, or an SE0, returns to IDLE silently.
  - DATA:
    - Ones counter increments on 1 and clears on 0.
    - When the ones count reaches 6, the next sampled bit is a stuffed bit. If it is 0, discard it and clear the counter. If it is 1, pulse rx_err and go to EOP.
    - Non-stuffed bits shift LSB-first. On the 8th bit, rx_data updates and rx_valid pulses in the cycle after that sample. The bit counter wraps 3'b111->0.
    - Sampled SE0 goes to EOP and records aligned = (bit counter == 0).
    - Sampled SE1 pulses rx_err and goes to EOP.
  - EOP:
    - Wait for sampled J.
    - If the entry was via SE0 with aligned set and no error, pulse pkt_end.
    - If the entry was via SE0 and misaligned, pulse rx_err instead.
    - Then go to IDLE.
- Precedence: rx_valid and pkt_end never coincide. The stuff-error rx_err replaces the byte; no partial byte is emitted.
- Bus reset:
  - Counter of consecutive synchronised SE0 cycles, saturating at RESET_CYCLES.
  - usb_reset rises in the cycle the count reaches RESET_CYCLES and falls the cycle after SE0 ends.
  - While usb_reset is high the FSM is held in IDLE and pkt_end/rx_err are suppressed.
- rx_en low: FSM forced to IDLE at the next edge and all pulses suppressed. The bus-reset counter keeps running.
- reset_n asserted mid-packet: immediate return to reset values. After release, no output until a fresh SYNC.
- Drift tolerance: resynchronisation on every transition; correct with a host bit period of 4 +/- 1 clocks on isolated bits.

Decomposition:
- Package usb_fs_pkg:
  - line-state enum (J, K, SE0, SE1)
  - rx FSM state enum
  - constant SYNC_PID_BITS = 8
  - constant STUFF_LIMIT = 6
- Sub-module usb_fs_bit_recovery: synchroniser, line-state decode and phase counter. Outputs line_state and bit_strobe to the framing FSM.

Test Plan:
- SETUP token: SYNC + bytes 8'h2D, 8'h00, 8'h10 + SE0 SE0 J -> one pkt_start; rx_valid x3 with 2D, 00, 10 in order; one pkt_end; rx_err never asserted.
- Stuffing: data 8'hFF, 8'hFF with stuffed zeros inserted after every 6 ones -> rx_data FF, FF; no rx_err; pkt_end.
- Stuff error: seven consecutive 1s after the PID -> rx_err pulse; no rx_valid for that byte; no pkt_end.
- Misaligned EOP: SE0 after 12 data bits -> rx_valid once; then rx_err; no pkt_end.
- Bus reset: SE0 held 200 clocks -> usb_reset high exactly at clock 120 of SE0, low one clock after J returns. SE0 of 119 clocks -> usb_reset stays 0.
- Echo/reset: rx_en = 0 during a full packet -> no pulses. reset_n pulsed low mid-byte -> all outputs 0; the next packet decodes correctly.
